// File: rtl/cmi_xfer_seq_pkg.sv
// cmi_pkg: shared types and defaults for the CMI transfer sequencer.
//   cmi_state_e     - sequencer state encoding
//   TIMEOUT_CYC_DEF - default wait-state budget before NXM abort
//   CNT_W_DEF       - default wait counter width (must hold TIMEOUT_CYC)
package cmi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ADDR,
    ST_WDATA,
    ST_RWAIT,
    ST_WACK,
    ST_END,
    ST_ABORT
  } cmi_state_e;

  localparam int unsigned TIMEOUT_CYC_DEF = 255;
  localparam int unsigned CNT_W_DEF       = 8;

endpackage

// File: rtl/cmi_xfer_seq_if.sv
// cmi_xfer_seq_if: request/bus/strobe bundle around the CMI sequencer.
//   master - microcode request side plus CMI arbiter/slave responses
//   slave  - the sequencer: consumes requests/responses, drives strobes
interface cmi_xfer_seq_if;
  logic mem_req_h;
  logic mem_wr_h;
  logic two_ref_h;
  logic cmi_grant_l;
  logic cmi_rdy_l;
  logic cmi_req_l;
  logic cmi_hold_l;
  logic are_l;
  logic ena_cmi_l;
  logic snapshot_cmi_l;
  logic second_ref_h;
  logic busy_h;
  logic done_h;
  logic nxm_err_h;

  modport master (
    output mem_req_h, mem_wr_h, two_ref_h, cmi_grant_l, cmi_rdy_l,
    input  cmi_req_l, cmi_hold_l, are_l, ena_cmi_l, snapshot_cmi_l,
           second_ref_h, busy_h, done_h, nxm_err_h
  );

  modport slave (
    input  mem_req_h, mem_wr_h, two_ref_h, cmi_grant_l, cmi_rdy_l,
    output cmi_req_l, cmi_hold_l, are_l, ena_cmi_l, snapshot_cmi_l,
           second_ref_h, busy_h, done_h, nxm_err_h
  );
endinterface

// File: rtl/cmi_xfer_seq_wait_timer.sv
// cmi_wait_timer: wait-state counter for the CMI sequencer.
//   i_clk   - clock
//   i_rst_n - synchronous active-low reset
//   i_clr   - clear count to zero (priority over enable)
//   i_en    - count one wait cycle
//   o_hit   - count equals LIMIT
module cmi_wait_timer #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_hit = (r_cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/cmi_xfer_seq.sv
// cmi_xfer_seq: sequences CMI references for the memory data path and
// generates the MDR control strobes.
//   b_clk_l  - system clock (state updates on rising edge)
//   reset_l  - synchronous active-low reset
//   bus      - request inputs, CMI grant/ready, and all sequencer outputs
//              (cmi_req_l, cmi_hold_l, are_l, ena_cmi_l, snapshot_cmi_l,
//               second_ref_h, busy_h, done_h, nxm_err_h)
module cmi_xfer_seq
  import cmi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic           b_clk_l,
  input  logic           reset_l,
  cmi_xfer_seq_if.slave  bus
);

  cmi_state_e r_state;
  cmi_state_e w_next;
  logic       r_wr;
  logic       r_two;
  logic       r_second;
  logic       r_nxm;
  logic       w_hit;
  logic       w_wait;
  logic       w_more;
  logic       w_accept;

  assign w_wait   = (r_state == ST_RWAIT) || (r_state == ST_WACK);
  assign w_more   = r_two & ~r_second;
  assign w_accept = (r_state == ST_IDLE) && bus.mem_req_h;

  // Timeout fires on a cycle whose registered count already equals the
  // limit while ready is still high, so ready sampled that cycle wins.
  cmi_wait_timer #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .i_clk   (b_clk_l),
    .i_rst_n (reset_l),
    .i_clr   (r_state == ST_ADDR),
    .i_en    (w_wait && bus.cmi_rdy_l && !w_hit),
    .o_hit   (w_hit)
  );

  always_ff @(posedge b_clk_l) begin
    if (!reset_l) begin
      r_state  <= ST_IDLE;
      r_wr     <= 1'b0;
      r_two    <= 1'b0;
      r_second <= 1'b0;
      r_nxm    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_wr  <= bus.mem_wr_h;
        r_two <= bus.two_ref_h;
        r_nxm <= 1'b0;
      end
      if (w_next == ST_ABORT) r_nxm <= 1'b1;
      if (r_state == ST_END)        r_second <= w_more;
      else if (r_state == ST_ABORT) r_second <= 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.mem_req_h) w_next = ST_ARB;
      ST_ARB:   if (!bus.cmi_grant_l) w_next = ST_ADDR;
      ST_ADDR:  w_next = r_wr ? ST_WDATA : ST_RWAIT;
      ST_WDATA: w_next = ST_WACK;
      ST_RWAIT, ST_WACK: begin
        if (!bus.cmi_rdy_l) w_next = ST_END;
        else if (w_hit)     w_next = ST_ABORT;
      end
      ST_END:   w_next = w_more ? ST_ADDR : ST_IDLE;
      ST_ABORT: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cmi_req_l      = 1'b1;
    bus.cmi_hold_l     = 1'b1;
    bus.are_l          = 1'b1;
    bus.ena_cmi_l      = 1'b1;
    bus.snapshot_cmi_l = 1'b1;
    bus.busy_h         = 1'b0;
    bus.done_h         = 1'b0;
    bus.second_ref_h   = r_second;
    bus.nxm_err_h      = r_nxm;
    case (r_state)
      ST_IDLE:  bus.are_l = ~(bus.mem_req_h & reset_l);
      ST_ARB: begin
        bus.cmi_req_l = 1'b0;
        bus.busy_h    = 1'b1;
      end
      ST_ADDR, ST_WDATA: begin
        bus.ena_cmi_l  = 1'b0;
        bus.cmi_hold_l = 1'b0;
        bus.busy_h     = 1'b1;
      end
      ST_RWAIT: begin
        bus.cmi_hold_l     = 1'b0;
        bus.snapshot_cmi_l = bus.cmi_rdy_l;
        bus.busy_h         = 1'b1;
      end
      ST_WACK: begin
        bus.cmi_hold_l = 1'b0;
        bus.busy_h     = 1'b1;
      end
      ST_END: begin
        bus.busy_h = 1'b1;
        if (w_more) begin
          bus.are_l      = 1'b0;
          bus.cmi_hold_l = 1'b0;
        end else begin
          bus.done_h = 1'b1;
        end
      end
      ST_ABORT: begin
        bus.busy_h = 1'b1;
        bus.done_h = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cmi_xfer_seq.sv
// Directed bench for cmi_xfer_seq. Each scenario drives 16 cycles of inputs
// from bit masks (bit c = cycle c, cycle 0 is the request cycle) and records
// every output per cycle as an asserted-high mask, then compares each mask
// to a hand-derived constant.
module tb_cmi_xfer_seq;

  logic b_clk_l = 1'b0;
  logic reset_l;
  int   n_checks = 0;
  int   n_fail   = 0;

  cmi_xfer_seq_if bus ();

  cmi_xfer_seq #(
    .TIMEOUT_CYC (4),
    .CNT_W       (8)
  ) dut (
    .b_clk_l (b_clk_l),
    .reset_l (reset_l),
    .bus     (bus)
  );

  always #5 b_clk_l = ~b_clk_l;

  logic [15:0] m_are, m_req, m_ena, m_snap, m_hold, m_busy, m_done, m_sec, m_nxm;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Entered at posedge+1; leaves at posedge+1 after 16 cycles.
  task automatic run(input logic [15:0] req, input logic [15:0] gnt,
                     input logic [15:0] rdy, input logic [15:0] rst,
                     input logic wr, input logic two);
    for (int c = 0; c < 16; c++) begin
      bus.mem_req_h   = req[c];
      bus.mem_wr_h    = wr;
      bus.two_ref_h   = two;
      bus.cmi_grant_l = ~gnt[c];
      bus.cmi_rdy_l   = ~rdy[c];
      reset_l         = ~rst[c];
      @(negedge b_clk_l);
      m_are[c]  = ~bus.are_l;
      m_req[c]  = ~bus.cmi_req_l;
      m_ena[c]  = ~bus.ena_cmi_l;
      m_snap[c] = ~bus.snapshot_cmi_l;
      m_hold[c] = ~bus.cmi_hold_l;
      m_busy[c] = bus.busy_h;
      m_done[c] = bus.done_h;
      m_sec[c]  = bus.second_ref_h;
      m_nxm[c]  = bus.nxm_err_h;
      @(posedge b_clk_l);
      #1;
    end
    bus.mem_req_h   = 1'b0;
    bus.cmi_grant_l = 1'b1;
    bus.cmi_rdy_l   = 1'b1;
    reset_l         = 1'b1;
  endtask

  task automatic verify(input string t,
                        input logic [15:0] are, input logic [15:0] req,
                        input logic [15:0] ena, input logic [15:0] snap,
                        input logic [15:0] hold, input logic [15:0] busy,
                        input logic [15:0] done, input logic [15:0] sec,
                        input logic [15:0] nxm);
    chk({t, " are"},  m_are,  are);
    chk({t, " req"},  m_req,  req);
    chk({t, " ena"},  m_ena,  ena);
    chk({t, " snap"}, m_snap, snap);
    chk({t, " hold"}, m_hold, hold);
    chk({t, " busy"}, m_busy, busy);
    chk({t, " done"}, m_done, done);
    chk({t, " sec"},  m_sec,  sec);
    chk({t, " nxm"},  m_nxm,  nxm);
  endtask

  initial begin
    reset_l         = 1'b0;
    bus.mem_req_h   = 1'b0;
    bus.mem_wr_h    = 1'b0;
    bus.two_ref_h   = 1'b0;
    bus.cmi_grant_l = 1'b1;
    bus.cmi_rdy_l   = 1'b1;
    repeat (3) @(posedge b_clk_l);
    #1;
    chk("rst req",  16'(bus.cmi_req_l),      16'h1);
    chk("rst hold", 16'(bus.cmi_hold_l),     16'h1);
    chk("rst are",  16'(bus.are_l),          16'h1);
    chk("rst ena",  16'(bus.ena_cmi_l),      16'h1);
    chk("rst snap", 16'(bus.snapshot_cmi_l), 16'h1);
    chk("rst busy", 16'(bus.busy_h),         16'h0);
    chk("rst done", 16'(bus.done_h),         16'h0);
    chk("rst sec",  16'(bus.second_ref_h),   16'h0);
    chk("rst nxm",  16'(bus.nxm_err_h),      16'h0);
    reset_l = 1'b1;
    @(posedge b_clk_l);
    #1;

    // Read, immediate grant, ready on first RWAIT: done in 5th cycle.
    run(16'h0001, 16'h0002, 16'h0008, 16'h0000, 1'b0, 1'b0);
    verify("rd", 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h000C,
           16'h001E, 16'h0010, 16'h0000, 16'h0000);

    // Write, grant in 4th ARB cycle, two wait states in WACK.
    run(16'h0001, 16'h0010, 16'h0200, 16'h0000, 1'b1, 1'b0);
    verify("wr", 16'h0001, 16'h001E, 16'h0060, 16'h0000, 16'h03E0,
           16'h07FE, 16'h0400, 16'h0000, 16'h0000);

    // Two-reference read: one arbitration, two address/snapshot pairs.
    run(16'h0001, 16'h0002, 16'h0048, 16'h0000, 1'b0, 1'b1);
    verify("rd2", 16'h0011, 16'h0002, 16'h0024, 16'h0048, 16'h007C,
           16'h00FE, 16'h0080, 16'h00E0, 16'h0000);

    // Ready never arrives: count reaches 4, abort, sticky NXM.
    run(16'h0001, 16'h0002, 16'h0000, 16'h0000, 1'b0, 1'b0);
    verify("nxm", 16'h0001, 16'h0002, 16'h0004, 16'h0000, 16'h00FC,
           16'h01FE, 16'h0100, 16'h0000, 16'hFF00);

    // Next request clears NXM on its accepting edge.
    run(16'h0001, 16'h0002, 16'h0008, 16'h0000, 1'b0, 1'b0);
    verify("clr", 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h000C,
           16'h001E, 16'h0010, 16'h0000, 16'h0001);

    // Ready arrives in the cycle the count equals the limit: no error.
    run(16'h0001, 16'h0002, 16'h0080, 16'h0000, 1'b0, 1'b0);
    verify("lim", 16'h0001, 16'h0002, 16'h0004, 16'h0080, 16'h00FC,
           16'h01FE, 16'h0100, 16'h0000, 16'h0000);

    // Two-reference write, reset asserted during second WACK.
    run(16'h0001, 16'h0002, 16'h0010, 16'h0100, 1'b1, 1'b1);
    verify("rstx", 16'h0021, 16'h0002, 16'h00CC, 16'h0000, 16'h01FC,
           16'h01FE, 16'h0000, 16'h01C0, 16'h0000);

    // Normal read after the reset abort.
    run(16'h0001, 16'h0002, 16'h0008, 16'h0000, 1'b0, 1'b0);
    verify("post", 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h000C,
           16'h001E, 16'h0010, 16'h0000, 16'h0000);

    // Request held high: restarts only from the IDLE cycle after done.
    run(16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    verify("hold", 16'h0421, 16'h0842, 16'h1084, 16'h2108, 16'h318C,
           16'h7BDE, 16'h4210, 16'h0000, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmi_xfer_seq.md
Name: cmi_xfer_seq

Overview:
- Sequences CMI bus references for the memory data path, directly upstream of the MDR slices.
- Arbitrates for the CMI and produces the MDR control strobes: are_l (CMI address register load), ena_cmi_l (CMI drive enable; MDR delays it internally for address then WDR data) and snapshot_cmi_l (read-data latch).
- Handles single and two-reference (unaligned) transfers, slave wait states, and non-existent-memory timeout.

Parameters:
- TIMEOUT_CYC, 255: wait-state cycles allowed before NXM abort (1..255).
- CNT_W, 8: width of the wait counter; must hold TIMEOUT_CYC.

Ports:
- b_clk_l  in  1  system clock; all state updates on its active edge, same edge as the MDR flops.
- reset_l  in  1  reset; synchronous, active-low.
- mem_req_h  in  1  microcode memory request, sampled only in IDLE.
- mem_wr_h  in  1  1 = write, 0 = read; qualified by mem_req_h.
- two_ref_h  in  1  unaligned access needing a second reference; qualified by mem_req_h.
- cmi_grant_l  in  1  CMI arbitration grant.
- cmi_rdy_l  in  1  slave ready: read data valid, or write accepted.
- cmi_req_l  out  1  CMI arbitration request.
- cmi_hold_l  out  1  hold bus ownership across both references.
- are_l  out  1  to MDR: load CMI address register from PA.
- ena_cmi_l  out  1  to MDR: enable CMI drivers.
- snapshot_cmi_l  out  1  to MDR: latch CMI read data.
- second_ref_h  out  1  second reference in progress; microcode uses it to select the DR rotate.
- busy_h  out  1  transfer in progress.
- done_h  out  1  one-cycle completion pulse.
- nxm_err_h  out  1  sticky timeout flag.

Behaviour:
- Reset (reset_l = 0 at an edge):
  - state IDLE; all _l outputs 1; busy_h, done_h, second_ref_h, nxm_err_h all 0; counter 0.
  - Reset mid-transfer aborts with no done_h pulse; bus released on the same edge.
- Registered latches: wr_q and two_q are loaded on the edge that accepts a request.
- IDLE:
  - On mem_req_h = 1: are_l = 0 for this cycle, clear nxm_err_h, go to ARB.
  - Requests arriving in any other state are ignored; no queuing.
- ARB:
  - cmi_req_l = 0 and busy_h = 1.
  - When cmi_grant_l = 0 is sampled, go to ADDR; cmi_req_l deasserts on entry to ADDR.
  - Waits indefinitely; no timeout in ARB.
- ADDR:
  - ena_cmi_l = 0 for exactly 1 cycle.
  - cmi_hold_l = 0 from ADDR through the final reference.
  - Next state is WDATA if wr_q, else RWAIT. Counter cleared.
- WDATA:
  - ena_cmi_l = 0 for 1 more cycle, so it is low for 2 contiguous cycles on a write.
  - Next state WACK.
- RWAIT / WACK:
  - Counter increments each cycle that cmi_rdy_l = 1.
  - When cmi_rdy_l = 0 in RWAIT: snapshot_cmi_l = 0 that same cycle, then go to END.
  - When cmi_rdy_l = 0 in WACK: go to END.
  - If the counter equals TIMEOUT_CYC with cmi_rdy_l still 1: go to ABORT.
  - cmi_rdy_l = 0 in the same cycle the counter hits the limit: ready wins, no error.
- END:
  - If two_q = 1 and second_ref_h = 0: set second_ref_h = 1, are_l = 0 this cycle, return to ADDR with no re-arbitration; cmi_hold_l stays 0.
  - Otherwise: done_h = 1, second_ref_h cleared, cmi_hold_l released, return to IDLE.
- ABORT:
  - nxm_err_h = 1 and done_h = 1 for 1 cycle.
  - Bus released, second_ref_h cleared, go to IDLE; a pending second reference is skipped.
- Latency with zero wait states:
  - Read: request edge to done_h is 5 cycles (IDLE→ARB with immediate grant →ADDR→RWAIT→END).
  - Write: 6 cycles.
- Output glitch-freedom: every _l strobe is decoded directly from the registered state plus registered or sampled inputs.

Decomposition:
- Package cmi_pkg holds:
  - the state enum (IDLE, ARB, ADDR, WDATA, RWAIT, WACK, END, ABORT);
  - the default TIMEOUT_CYC constant.
- Sub-module cmi_wait_timer: counter with clear, enable, and limit-compare (hit) output.
- The FSM stays in the top module.

Test Plan:
- Read, grant immediate, cmi_rdy_l low on the 1st RWAIT cycle:
  - are_l low 1 cycle, ena_cmi_l low 1 cycle, snapshot_cmi_l low 1 cycle;
  - done_h 5 cycles after request; nxm_err_h = 0.
- Write, grant after 3 cycles, 2 wait states:
  - cmi_req_l low 4 cycles; ena_cmi_l low exactly 2 consecutive cycles; done_h after WACK plus END.
- Two-reference read:
  - two are_l pulses, two snapshot_cmi_l pulses, a single arbitration;
  - cmi_hold_l low continuously; second_ref_h high during the second reference; exactly one done_h.
- Read with cmi_rdy_l held high, TIMEOUT_CYC = 4:
  - ABORT after 4 wait cycles; nxm_err_h = 1 (sticky), done_h 1 pulse;
  - the next request clears nxm_err_h.
- reset_l low during WACK of a two-reference write:
  - next cycle all strobes 1, busy_h = 0, no done_h;
  - a new request afterwards completes normally.
- mem_req_h held high during a transfer:
  - no re-trigger while busy; a new transfer starts only from the IDLE cycle after done_h.
